// File: rtl/icb_cmd_arb_mux.sv
// N-master to 1-slave ICB command/response multiplexer driven by an external round-robin arbiter.
// The grant is held while the slave stalls, and an outstanding FIFO routes in-order responses back.
module icb_cmd_arb_mux #(
   parameter int CHN_N     = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int OUTSTD    = 4,
   parameter int SIM_DELAY = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CHN_N*ADDR_W-1:0]     s_cmd_addr,
   input  logic [CHN_N-1:0]            s_cmd_read,
   input  logic [CHN_N*DATA_W-1:0]     s_cmd_wdata,
   input  logic [CHN_N*DATA_W/8-1:0]   s_cmd_wmask,
   input  logic [CHN_N-1:0]            s_cmd_valid,
   output logic [CHN_N-1:0]            s_cmd_ready,
   output logic [CHN_N*DATA_W-1:0]     s_rsp_rdata,
   output logic [CHN_N-1:0]            s_rsp_err,
   output logic [CHN_N-1:0]            s_rsp_valid,
   input  logic [CHN_N-1:0]            s_rsp_ready,
   output logic [ADDR_W-1:0]           m_cmd_addr,
   output logic                        m_cmd_read,
   output logic [DATA_W-1:0]           m_cmd_wdata,
   output logic [DATA_W/8-1:0]         m_cmd_wmask,
   output logic                        m_cmd_valid,
   input  logic                        m_cmd_ready,
   input  logic [DATA_W-1:0]           m_rsp_rdata,
   input  logic                        m_rsp_err,
   input  logic                        m_rsp_valid,
   output logic                        m_rsp_ready,
   output logic [CHN_N-1:0]            arb_req,
   input  logic [CHN_N-1:0]            arb_grant,
   input  logic [$clog2(CHN_N)-1:0]    arb_sel,
   input  logic                        arb_valid
);

   localparam int SEL_W  = $clog2(CHN_N);
   localparam int PTR_W  = $clog2(OUTSTD);
   localparam int CNT_W  = PTR_W + 1;
   localparam int MASK_W = DATA_W / 8;

   // The delay parameter is kept for drop-in compatibility; the binary arb_sel makes the grant vector redundant.
   localparam int unused_sim_delay = SIM_DELAY;
   logic unused_grant;
   assign unused_grant = ^arb_grant;

   typedef enum logic {ST_ARB, ST_LOCK} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] lock_sel, cur_sel, head;
   logic [SEL_W-1:0] fifo_q [OUTSTD];
   logic [PTR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0] cnt;
   logic             full, empty, push, pop, grant_rdy;

   assign full    = (cnt == CNT_W'(OUTSTD));
   assign empty   = (cnt == '0);
   assign cur_sel = (state == ST_LOCK) ? lock_sel : arb_sel;
   assign head    = fifo_q[rptr];

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      arb_req     = '0;
      m_cmd_valid = 1'b0;
      grant_rdy   = 1'b0;
      s_cmd_ready = '0;
      case (state)
         ST_ARB: begin
            arb_req     = full ? '0 : s_cmd_valid;
            m_cmd_valid = arb_valid & ~full;
            grant_rdy   = m_cmd_ready & ~full;
            if (m_cmd_valid && !m_cmd_ready) state_nxt = ST_LOCK;
         end
         ST_LOCK: begin
            m_cmd_valid = 1'b1;
            grant_rdy   = m_cmd_ready;
            if (m_cmd_ready) state_nxt = ST_ARB;
         end
         default: state_nxt = ST_ARB;
      endcase
      s_cmd_ready[cur_sel] = grant_rdy;
   end

   assign m_cmd_addr  = s_cmd_addr[cur_sel*ADDR_W +: ADDR_W];
   assign m_cmd_read  = s_cmd_read[cur_sel];
   assign m_cmd_wdata = s_cmd_wdata[cur_sel*DATA_W +: DATA_W];
   assign m_cmd_wmask = s_cmd_wmask[cur_sel*MASK_W +: MASK_W];
   assign push        = m_cmd_valid & m_cmd_ready;

   // Responses return in order, so only the FIFO head may see the slave's response.
   always_comb begin
      s_rsp_valid = '0;
      m_rsp_ready = 1'b0;
      if (!empty) begin
         s_rsp_valid[head] = m_rsp_valid;
         m_rsp_ready       = s_rsp_ready[head];
      end
   end

   assign s_rsp_rdata = {CHN_N{m_rsp_rdata}};
   assign s_rsp_err   = {CHN_N{m_rsp_err}};
   assign pop         = m_rsp_valid & m_rsp_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_ARB;
         lock_sel <= '0;
         wptr     <= '0;
         rptr     <= '0;
         cnt      <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_ARB && m_cmd_valid && !m_cmd_ready) lock_sel <= arb_sel;
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: the storage array has no reset; an entry is only read after a push has written it.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wptr] <= cur_sel;
   end

endmodule

// File: tb/tb_icb_cmd_arb_mux.sv
// Directed bench for icb_cmd_arb_mux with a small round-robin arbiter model driving arb_*.
// A per-cycle vector table covers fill/full/pop; hand-written sequences cover lock, response stall and reset.
module tb_icb_cmd_arb_mux;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] s_cmd_addr;
   logic [3:0]   s_cmd_read;
   logic [127:0] s_cmd_wdata;
   logic [15:0]  s_cmd_wmask;
   logic [3:0]   s_cmd_valid;
   logic [3:0]   s_cmd_ready;
   logic [127:0] s_rsp_rdata;
   logic [3:0]   s_rsp_err;
   logic [3:0]   s_rsp_valid;
   logic [3:0]   s_rsp_ready;
   logic [31:0]  m_cmd_addr;
   logic         m_cmd_read;
   logic [31:0]  m_cmd_wdata;
   logic [3:0]   m_cmd_wmask;
   logic         m_cmd_valid;
   logic         m_cmd_ready;
   logic [31:0]  m_rsp_rdata;
   logic         m_rsp_err;
   logic         m_rsp_valid;
   logic         m_rsp_ready;
   logic [3:0]   arb_req;
   logic [3:0]   arb_grant;
   logic [1:0]   arb_sel;
   logic         arb_valid;

   int n_chk = 0;
   int n_err = 0;

   icb_cmd_arb_mux dut (
      .clk(clk), .rst_n(rst_n),
      .s_cmd_addr(s_cmd_addr), .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata),
      .s_cmd_wmask(s_cmd_wmask), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err), .s_rsp_valid(s_rsp_valid),
      .s_rsp_ready(s_rsp_ready),
      .m_cmd_addr(m_cmd_addr), .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata),
      .m_cmd_wmask(m_cmd_wmask), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
      .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err), .m_rsp_valid(m_rsp_valid),
      .m_rsp_ready(m_rsp_ready),
      .arb_req(arb_req), .arb_grant(arb_grant), .arb_sel(arb_sel), .arb_valid(arb_valid)
   );

   always #5 clk = ~clk;

   // Round-robin arbiter model: priority starts at rr_ptr and moves past each granted channel.
   logic [1:0] rr_ptr;
   always_comb begin
      arb_valid = 1'b0;
      arb_sel   = 2'd0;
      arb_grant = 4'b0000;
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = rr_ptr + k[1:0];
            if (!arb_valid && arb_req[idx]) begin
               arb_valid      = 1'b1;
               arb_sel        = idx;
               arb_grant[idx] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         rr_ptr <= 2'd0;
      else if (arb_valid) rr_ptr <= arb_sel + 2'd1;
   end

   function automatic logic [31:0] addr_of(input int ch);
      return 32'h1000_0000 + 32'(ch) * 32'h100;
   endfunction
   function automatic logic [31:0] wdata_of(input int ch);
      return 32'hA5A5_0000 + 32'(ch);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] cv, input logic cr, input logic rv, input logic [3:0] rr);
      s_cmd_valid = cv;
      m_cmd_ready = cr;
      m_rsp_valid = rv;
      s_rsp_ready = rr;
   endtask

   task automatic check_outs(input string nm, input logic [3:0] e_req, input logic e_mv,
                             input logic [1:0] e_ch, input logic [3:0] e_crdy,
                             input logic e_rrdy, input logic [3:0] e_rv);
      check({nm, ".arb_req"},     arb_req,     e_req);
      check({nm, ".m_cmd_valid"}, m_cmd_valid, e_mv);
      check({nm, ".s_cmd_ready"}, s_cmd_ready, e_crdy);
      check({nm, ".m_rsp_ready"}, m_rsp_ready, e_rrdy);
      check({nm, ".s_rsp_valid"}, s_rsp_valid, e_rv);
      if (e_mv) begin
         check({nm, ".m_cmd_addr"},  m_cmd_addr,  addr_of(int'(e_ch)));
         check({nm, ".m_cmd_wdata"}, m_cmd_wdata, wdata_of(int'(e_ch)));
         check({nm, ".m_cmd_wmask"}, m_cmd_wmask, 4'b0001 << e_ch);
         check({nm, ".m_cmd_read"},  m_cmd_read,  e_ch[0]);
      end
   endtask

   typedef struct {
      string      nm;
      logic [3:0] cv;
      logic       cr;
      logic       rv;
      logic [3:0] rr;
      logic [3:0] e_req;
      logic       e_mv;
      logic [1:0] e_ch;
      logic [3:0] e_crdy;
      logic       e_rrdy;
      logic [3:0] e_rv;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // Fill to full, block, pop-while-full, refill, push+pop, drain, then a stray response on an empty FIFO.
      tbl.push_back('{"fill_ch0",   4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000});
      tbl.push_back('{"fill_ch1",   4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b0, 4'b0000});
      tbl.push_back('{"fill_ch2",   4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0, 4'b0000});
      tbl.push_back('{"fill_ch3",   4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd3, 4'b1000, 1'b0, 4'b0000});
      tbl.push_back('{"full_block", 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000});
      tbl.push_back('{"full_pop",   4'b1111, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0001});
      tbl.push_back('{"refill_ch0", 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000});
      tbl.push_back('{"pop_ch1",    4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0010});
      tbl.push_back('{"push_pop",   4'b1111, 1'b1, 1'b1, 4'b0100, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0100});
      tbl.push_back('{"pop_ch3",    4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b1000});
      tbl.push_back('{"pop_ch0",    4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0001});
      tbl.push_back('{"pop_ch1b",   4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0010});
      tbl.push_back('{"rsp_empty",  4'b0000, 1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000});

      for (int i = 0; i < 4; i++) begin
         s_cmd_addr[i*32 +: 32]  = addr_of(i);
         s_cmd_wdata[i*32 +: 32] = wdata_of(i);
         s_cmd_wmask[i*4 +: 4]   = 4'b0001 << i;
         s_cmd_read[i]           = i[0];
      end
      m_rsp_rdata = 32'h0;
      m_rsp_err   = 1'b0;

      // Reset with every master requesting: nothing issued, no responses routed.
      rst_n = 1'b0;
      drive(4'b1111, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      @(negedge clk);
      #2;
      check_outs("reset", 4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);
      check("reset.s_rsp_err", s_rsp_err, 4'b0000);

      @(negedge clk);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         if (i != 0) @(negedge clk);
         drive(tbl[i].cv, tbl[i].cr, tbl[i].rv, tbl[i].rr);
         #2;
         check_outs(tbl[i].nm, tbl[i].e_req, tbl[i].e_mv, tbl[i].e_ch, tbl[i].e_crdy,
                    tbl[i].e_rrdy, tbl[i].e_rv);
      end

      // Slave stalls ch2 for three cycles while ch1 starts requesting; the grant must stay on ch2.
      @(negedge clk); drive(4'b0100, 1'b0, 1'b0, 4'b0000); #2;
      check_outs("lock_c0", 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000);
      @(negedge clk); drive(4'b0110, 1'b0, 1'b0, 4'b0000); #2;
      check_outs("lock_c1", 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000);
      @(negedge clk); drive(4'b0110, 1'b0, 1'b0, 4'b0000); #2;
      check_outs("lock_c2", 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000);
      @(negedge clk); drive(4'b0110, 1'b1, 1'b0, 4'b0000); #2;
      check_outs("lock_accept", 4'b0000, 1'b1, 2'd2, 4'b0100, 1'b0, 4'b0000);
      @(negedge clk); drive(4'b0010, 1'b1, 1'b0, 4'b0000); #2;
      check_outs("after_lock_ch1", 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b0, 4'b0000);
      @(negedge clk); drive(4'b1000, 1'b1, 1'b0, 4'b0000); #2;
      check_outs("issue_ch3", 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b0, 4'b0000);

      // Outstanding {2,1,3}: retire ch2, then stall ch1's response for two cycles before ch3's.
      @(negedge clk); drive(4'b0000, 1'b0, 1'b1, 4'b0100); #2;
      check_outs("rsp_ch2", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0100);
      m_rsp_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); drive(4'b0000, 1'b0, 1'b1, 4'b1101); #2;
         check_outs("rsp_ch1_stall", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0010);
         check("rsp_ch1_stall.rdata", s_rsp_rdata[63:32], 32'hDEAD_BEEF);
      end
      @(negedge clk); drive(4'b0000, 1'b0, 1'b1, 4'b0010); #2;
      check_outs("rsp_ch1_pop", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0010);
      m_rsp_rdata = 32'hCAFE_F00D;
      m_rsp_err   = 1'b1;
      @(negedge clk); drive(4'b0000, 1'b0, 1'b1, 4'b1000); #2;
      check_outs("rsp_ch3", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b1000);
      check("rsp_ch3.rdata", s_rsp_rdata[127:96], 32'hCAFE_F00D);
      check("rsp_ch3.err", s_rsp_err, 4'b1111);
      m_rsp_err = 1'b0;

      // Reset while locked with one response outstanding: everything clears at once.
      @(negedge clk); drive(4'b0001, 1'b1, 1'b0, 4'b0000); #2;
      check_outs("pre_rst_push", 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000);
      @(negedge clk); drive(4'b0001, 1'b0, 1'b1, 4'b0000); #2;
      check_outs("pre_rst_stall", 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0001);
      @(negedge clk); drive(4'b0001, 1'b0, 1'b1, 4'b1111); #2;
      rst_n = 1'b0;
      #1;
      check_outs("mid_rst", 4'b0001, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0000, 1'b0, 1'b1, 4'b1111); #2;
      check_outs("post_rst_empty", 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000);
      @(negedge clk); drive(4'b0010, 1'b1, 1'b0, 4'b0000); #2;
      check_outs("post_rst_arb", 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
